// File: rtl/ipsmacge_rgmiirx.sv
// ipsmacge_rgmiirx -- RGMII receive framer.
//
// Turns re-timed RGMII receive symbols into a byte stream with start/end
// markers, frame length and a bad-frame flag. Handles 1000 Mb/s (one byte
// per clock) and 10/100 Mb/s (one nibble per clock, low nibble first).
//
// Ports
//   rxclk            receive clock (only clock)
//   rxrst_           asynchronous active-low reset
//   speed1g          1 = byte per clock, 0 = nibble per clock
//   idat_h[4:0]      {ctl, rxd[3:0]} from the rising edge
//   idat_l[4:0]      {ctl, rxd[7:4]} from the falling edge
//   odat[7:0]        frame byte, holds when ovld=0
//   ovld             odat valid (single-cycle pulse)
//   osof / oeof      first / last byte of frame, qualified by ovld
//   oerr             frame bad, valid with oeof
//   olen[13:0]       frame byte count, valid with oeof
//   olink/ospeed/oduplex  in-band link status
//
// Build option
//   IPSMACGE_RGMIIRX_INBAND_EN  when defined, olink/ospeed/oduplex follow
//   the in-band status carried during idle; otherwise they are tied to
//   link up, 1000 Mb/s, full duplex.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame; waiting for dv with a preamble symbol
// PRE   | counting preamble symbols, waiting for SFD
// DATA  | assembling bytes, one byte held back to find the last one
// DROP  | malformed start; swallow symbols until dv falls

module ipsmacge_rgmiirx #(
  parameter int MINPRE = 1,
  parameter int MAXLEN = 1522
) (
  input  logic        rxclk,
  input  logic        rxrst_,
  input  logic        speed1g,
  input  logic [4:0]  idat_h,
  input  logic [4:0]  idat_l,
  output logic [7:0]  odat,
  output logic        ovld,
  output logic        osof,
  output logic        oeof,
  output logic        oerr,
  output logic [13:0] olen,
  output logic        olink,
  output logic [1:0]  ospeed,
  output logic        oduplex
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  // Nibble mode needs two preamble nibbles per preamble byte.
  localparam logic [7:0]  PRE_1G  = 8'(MINPRE);
  localparam logic [7:0]  PRE_NB  = 8'(2 * MINPRE);
  localparam logic [13:0] MAX_L   = 14'(MAXLEN);
  localparam logic [13:0] LEN_SAT = 14'h3fff;

  // Input stage: one register so decode works on stable, aligned symbols.
  logic [4:0] dh_q, dl_q;
  logic       spd_q;

  state_t      state_q, state_d;
  logic        lat_q, lat_d;
  logic [7:0]  pre_q, pre_d;
  logic [3:0]  lo_q, lo_d;
  logic        ph_q, ph_d;
  logic [7:0]  hold_q, hold_d;
  logic        hv_q, hv_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [13:0] cnt_q, cnt_d;

  logic [7:0]  odat_d;
  logic        ovld_d, osof_d, oeof_d, oerr_d;
  logic [13:0] olen_d;

  logic        dv, er, mode_1g, is_pre, is_sfd, pre_ok;
  logic [7:0]  byte_1g, byte_new;
  logic [3:0]  nib;
  logic        byte_done, emit, last, odd;
  logic [13:0] cnt_inc;

  assign dv      = dh_q[4];
  assign er      = dh_q[4] ^ dl_q[4];
  assign byte_1g = {dl_q[3:0], dh_q[3:0]};
  assign nib     = dh_q[3:0];
  // Speed is taken live only while idle, then frozen for the frame.
  assign mode_1g = (state_q == IDLE) ? spd_q : lat_q;
  assign is_pre  = mode_1g ? (byte_1g == 8'h55) : (nib == 4'h5);
  assign is_sfd  = mode_1g ? (byte_1g == 8'hd5) : (nib == 4'hd);
  assign pre_ok  = mode_1g ? (pre_q >= PRE_1G) : (pre_q >= PRE_NB);
  assign cnt_inc = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 14'd1;

  always_ff @(posedge rxclk or negedge rxrst_) begin
    if (!rxrst_) begin
      dh_q    <= '0;
      dl_q    <= '0;
      spd_q   <= 1'b0;
      state_q <= IDLE;
      lat_q   <= 1'b0;
      pre_q   <= '0;
      lo_q    <= '0;
      ph_q    <= 1'b0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      odat    <= '0;
      ovld    <= 1'b0;
      osof    <= 1'b0;
      oeof    <= 1'b0;
      oerr    <= 1'b0;
      olen    <= '0;
    end else begin
      dh_q    <= idat_h;
      dl_q    <= idat_l;
      spd_q   <= speed1g;
      state_q <= state_d;
      lat_q   <= lat_d;
      pre_q   <= pre_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      first_q <= first_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      odat    <= odat_d;
      ovld    <= ovld_d;
      osof    <= osof_d;
      oeof    <= oeof_d;
      oerr    <= oerr_d;
      olen    <= olen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    pre_d     = pre_q;
    lo_d      = lo_q;
    ph_d      = ph_q;
    hold_d    = hold_q;
    hv_d      = hv_q;
    first_d   = first_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    odat_d    = odat;
    ovld_d    = 1'b0;
    osof_d    = 1'b0;
    oeof_d    = 1'b0;
    oerr_d    = 1'b0;
    olen_d    = olen;
    byte_done = 1'b0;
    byte_new  = byte_1g;
    emit      = 1'b0;
    last      = 1'b0;
    odd       = 1'b0;

    case (state_q)
      IDLE: begin
        lat_d = spd_q;
        pre_d = '0;
        // dv=0 with er=1 (false carrier / extension) falls through here.
        if (dv) begin
          if (is_pre) begin
            state_d = PRE;
            pre_d   = 8'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!dv) begin
          state_d = IDLE;
        end else if (is_sfd) begin
          if (pre_ok) begin
            state_d = DATA;
            ph_d    = 1'b0;
            hv_d    = 1'b0;
            first_d = 1'b1;
            err_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = DROP;
          end
        end else if (is_pre) begin
          pre_d = (pre_q == 8'hff) ? pre_q : pre_q + 8'd1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (dv) begin
          err_d = err_q | er;
          if (mode_1g) begin
            byte_done = 1'b1;
          end else if (!ph_q) begin
            lo_d = nib;
            ph_d = 1'b1;
          end else begin
            byte_done = 1'b1;
            byte_new  = {nib, lo_q};
            ph_d      = 1'b0;
          end
          if (byte_done) begin
            emit   = hv_q;
            hold_d = byte_new;
            hv_d   = 1'b1;
          end
        end else begin
          // Frame end: flush the held byte as the last one, if any.
          state_d = IDLE;
          emit    = hv_q;
          last    = 1'b1;
          odd     = !mode_1g && ph_q;
          hv_d    = 1'b0;
        end
      end
      DROP: begin
        if (!dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      cnt_d   = cnt_inc;
      odat_d  = hold_q;
      ovld_d  = 1'b1;
      osof_d  = first_q;
      first_d = 1'b0;
      if (last) begin
        oeof_d = 1'b1;
        olen_d = cnt_inc;
        oerr_d = err_q | odd | (cnt_inc > MAX_L);
      end
    end
  end

`ifdef IPSMACGE_RGMIIRX_INBAND_EN
  // Status nibble must be identical on both edges and repeat on two
  // consecutive idle cycles before it is trusted.
  logic [3:0] ib_prev_q;
  logic       ib_ok_q;
  logic       ib_cond;

  assign ib_cond = !dv && !er && (dh_q[3:0] == dl_q[3:0]);

  always_ff @(posedge rxclk or negedge rxrst_) begin
    if (!rxrst_) begin
      ib_prev_q <= '0;
      ib_ok_q   <= 1'b0;
      olink     <= 1'b0;
      ospeed    <= '0;
      oduplex   <= 1'b0;
    end else begin
      ib_prev_q <= dh_q[3:0];
      ib_ok_q   <= ib_cond;
      if (ib_cond && ib_ok_q && (ib_prev_q == dh_q[3:0])) begin
        oduplex <= dh_q[3];
        ospeed  <= dh_q[2:1];
        olink   <= dh_q[0];
      end
    end
  end
`else
  assign olink   = 1'b1;
  assign ospeed  = 2'b10;
  assign oduplex = 1'b1;
`endif

endmodule

// File: tb/tb_ipsmacge_rgmiirx.sv
// Bench for ipsmacge_rgmiirx: directed frames in both speeds, errors,
// oversize, bad preamble, mid-frame reset, back-to-back, in-band status.
module tb_ipsmacge_rgmiirx;

  logic        rxclk, rxrst_, speed1g;
  logic [4:0]  idat_h, idat_l;
  logic [7:0]  odat;
  logic        ovld, osof, oeof, oerr;
  logic [13:0] olen;
  logic        olink, oduplex;
  logic [1:0]  ospeed;

  ipsmacge_rgmiirx dut (
    .rxclk(rxclk), .rxrst_(rxrst_), .speed1g(speed1g),
    .idat_h(idat_h), .idat_l(idat_l),
    .odat(odat), .ovld(ovld), .osof(osof), .oeof(oeof), .oerr(oerr),
    .olen(olen), .olink(olink), .ospeed(ospeed), .oduplex(oduplex)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  typedef struct {
    logic [7:0] d;
    bit         sof;
    bit         eof;
    bit         err;
    int         len;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   samp0 = 0;
  int   lat_exp = 2;
  bit   nib_mode = 0;
  int   last_vld = 0;
  int   nvld = 0;
  logic [7:0]  last_odat = 8'h00;
  logic [13:0] last_len = '0;
  logic        last_err = 1'b0;

  always @(posedge rxclk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Output checker: every cycle outside reset.
  always @(negedge rxclk) begin
    exp_t e;
    if (!rxrst_) begin
      last_odat = 8'h00;
    end else if (ovld) begin
      if (q.size() == 0) begin
        chk("unexpected_ovld", 32'(odat), 32'hffff_ffff);
      end else begin
        e = q.pop_front();
        chk("odat", 32'(odat), 32'(e.d));
        chk("osof", 32'(osof), 32'(e.sof));
        chk("oeof", 32'(oeof), 32'(e.eof));
        if (e.eof) begin
          chk("oerr", 32'(oerr), 32'(e.err));
          chk("olen", 32'(olen), 32'(e.len));
          last_len = olen;
          last_err = oerr;
        end
        if (e.sof)
          chk("latency", 32'(cyc - samp0), 32'(lat_exp));
        else if (!e.eof)
          chk("ovld_gap", 32'(cyc - last_vld), nib_mode ? 32'd2 : 32'd1);
      end
      last_vld  = cyc;
      last_odat = odat;
      nvld++;
    end else begin
      chk("pulse_idle", {30'd0, osof, oeof}, 32'd0);
      chk("odat_hold", 32'(odat), 32'(last_odat));
    end
  end

  task automatic send_b(input bit dv, input bit er, input logic [7:0] b);
    @(negedge rxclk);
    idat_h = {dv, b[3:0]};
    idat_l = {dv ^ er, b[7:4]};
  endtask

  task automatic send_n(input bit dv, input bit er, input logic [3:0] n);
    @(negedge rxclk);
    idat_h = {dv, n};
    idat_l = {dv ^ er, n};
  endtask

  // Spec-level model: every data byte comes out, in order, sof on the
  // first, eof on the last; the frame is bad on er, leftover nibble or
  // oversize; length is the byte count saturated at 16383.
  task automatic run_frame(input bit g1, input int n, input int er_at,
                           input bit extra, input int idle_after);
    exp_t e;
    bit   bad;
    speed1g  = g1;
    nib_mode = !g1;
    lat_exp  = g1 ? 2 : 3;
    bad = (er_at >= 0) || extra || (n > 1522);
    for (int i = 0; i < n; i++) begin
      e.d   = 8'(i);
      e.sof = (i == 0);
      e.eof = (i == n - 1);
      e.err = bad;
      e.len = (n > 16383) ? 16383 : n;
      q.push_back(e);
    end
    if (g1) begin
      repeat (7) send_b(1, 0, 8'h55);
      send_b(1, 0, 8'hd5);
      for (int i = 0; i < n; i++) begin
        send_b(1, i == er_at, 8'(i));
        if (i == 0) samp0 = cyc + 1;
      end
    end else begin
      repeat (15) send_n(1, 0, 4'h5);
      send_n(1, 0, 4'hd);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'(i);
        send_n(1, i == er_at, b[3:0]);
        send_n(1, i == er_at, b[7:4]);
        if (i == 0) samp0 = cyc + 1;
      end
      if (extra) send_n(1, 0, 4'ha);
    end
    repeat (idle_after) send_b(0, 0, 8'h00);
  endtask

  task automatic drain(input string nm);
    repeat (6) send_b(0, 0, 8'h00);
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n0;
    rxrst_  = 1'b0;
    speed1g = 1'b1;
    idat_h  = '0;
    idat_l  = '0;
    repeat (3) @(negedge rxclk);
    chk("rst_ovld", 32'(ovld), 32'd0);
    chk("rst_odat", 32'(odat), 32'd0);
    chk("rst_olen", 32'(olen), 32'd0);
    chk("rst_flags", {29'd0, osof, oeof, oerr}, 32'd0);
    rxrst_ = 1'b1;
    repeat (3) send_b(0, 0, 8'h00);

    // 1G 64-byte frame
    run_frame(1, 64, -1, 0, 2);
    drain("drain_1g64");
    chk("lit_1g64_len", 32'(last_len), 32'd64);
    chk("lit_1g64_err", 32'(last_err), 32'd0);

    // Nibble mode, same frame; then with a trailing nibble
    run_frame(0, 64, -1, 0, 2);
    drain("drain_nb64");
    chk("lit_nb64_len", 32'(last_len), 32'd64);
    chk("lit_nb64_err", 32'(last_err), 32'd0);
    run_frame(0, 64, -1, 1, 2);
    drain("drain_nb64x");
    chk("lit_nb64x_len", 32'(last_len), 32'd64);
    chk("lit_nb64x_err", 32'(last_err), 32'd1);

    // 1G er on byte 10 of 100
    run_frame(1, 100, 10, 0, 2);
    drain("drain_er");
    chk("lit_er_len", 32'(last_len), 32'd100);
    chk("lit_er_err", 32'(last_err), 32'd1);

    // Oversize
    run_frame(1, 1600, -1, 0, 2);
    drain("drain_big");
    chk("lit_big_len", 32'(last_len), 32'd1600);
    chk("lit_big_err", 32'(last_err), 32'd1);

    // Bad preamble -> dropped
    n0 = nvld;
    send_b(1, 0, 8'h55);
    send_b(1, 0, 8'h57);
    for (int i = 0; i < 20; i++) send_b(1, 0, 8'(i));
    drain("drain_drop");
    chk("drop_no_ovld", 32'(nvld), 32'(n0));

    // Reset at byte 20: bytes 0..17 are already out (2-clock latency)
    begin
      exp_t e;
      speed1g  = 1'b1;
      nib_mode = 1'b0;
      lat_exp  = 2;
      for (int i = 0; i < 18; i++) begin
        e.d = 8'(i); e.sof = (i == 0); e.eof = 0; e.err = 0; e.len = 0;
        q.push_back(e);
      end
      repeat (7) send_b(1, 0, 8'h55);
      send_b(1, 0, 8'hd5);
      for (int i = 0; i < 20; i++) begin
        send_b(1, 0, 8'(i));
        if (i == 0) samp0 = cyc + 1;
      end
      @(negedge rxclk);
      #2;
      rxrst_ = 1'b0;
      idat_h = '0;
      idat_l = '0;
      #1;
      chk("midrst_ovld", 32'(ovld), 32'd0);
      chk("midrst_odat", 32'(odat), 32'd0);
      chk("midrst_oeof", 32'(oeof), 32'd0);
      chk("midrst_olen", 32'(olen), 32'd0);
      repeat (2) @(negedge rxclk);
      rxrst_ = 1'b1;
      chk("midrst_queue", 32'(q.size()), 32'd0);
      repeat (3) send_b(0, 0, 8'h00);
    end

    // Frame after reset, then back-to-back with a single idle cycle
    run_frame(1, 64, -1, 0, 2);
    drain("drain_postrst");
    chk("lit_postrst_len", 32'(last_len), 32'd64);
    run_frame(1, 30, -1, 0, 1);
    run_frame(1, 40, 5, 0, 2);
    drain("drain_b2b");
    chk("lit_b2b_len", 32'(last_len), 32'd40);
    chk("lit_b2b_err", 32'(last_err), 32'd1);

`ifdef IPSMACGE_RGMIIRX_INBAND_EN
    repeat (4) send_n(0, 0, 4'hd);
    repeat (2) @(negedge rxclk);
    chk("inband_set", {28'd0, oduplex, ospeed, olink}, 32'hd);
    send_n(0, 0, 4'h2);
    for (int i = 0; i < 4; i++) begin
      send_n(0, 0, 4'hd);
      chk("inband_glitch", {28'd0, oduplex, ospeed, olink}, 32'hd);
    end
`else
    chk("inband_tie", {28'd0, oduplex, ospeed, olink}, 32'hd);
`endif

    repeat (2) @(negedge rxclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ipsmacge_rgmiirx.md
IPSMACGE_RGMIIRX -- requirements
Module: ipsmacge_rgmiirx

Interface
REQ-001 The block SHALL have the following parameters:
- MINPRE, default 1: minimum preamble bytes (0x55) before SFD.
- MAXLEN, default 1522: largest legal frame length in bytes, SFD excluded.
REQ-002 The block SHALL have the following ports:
- rxclk  in  1  receive clock; the only clock.
- rxrst_  in  1  asynchronous, active-low reset.
- speed1g  in  1  1 = 1000 Mb/s (byte per clock); 0 = 10/100 (nibble per clock).
- idat_h  in  5  {ctl, rxd[3:0]} captured on rising edge, re-timed to rxclk posedge.
- idat_l  in  5  {ctl, rxd[7:4]} captured on falling edge, re-timed to rxclk posedge.
- odat  out  8  frame byte.
- ovld  out  1  odat valid.
- osof  out  1  first byte of frame; qualified by ovld.
- oeof  out  1  last byte of frame; qualified by ovld.
- oerr  out  1  frame bad; valid with oeof.
- olen  out  14  frame byte count; valid with oeof.
- olink  out  1  in-band link status.
- ospeed  out  2  in-band speed.
- oduplex  out  1  in-band duplex.

Function
REQ-003 The block SHALL decode dv = idat_h[4] and er = idat_h[4] ^ idat_l[4] every cycle.
REQ-004 The block SHALL assemble symbols as follows:
- 1G mode: one byte per cycle, byte = {idat_l[3:0], idat_h[3:0]}.
- Nibble mode: idat_h[3:0] only, one nibble per cycle, low nibble first.
REQ-005 The block SHALL sample speed1g only in IDLE and hold it constant until the frame ends.
REQ-006 The FSM SHALL have the states IDLE, PRE, DATA and DROP.
REQ-007 The FSM SHALL leave IDLE as follows:
- dv=1 and symbol is 0x55 (1G) or nibble 0x5 -> PRE.
- dv=1 and any other symbol -> DROP.
REQ-008 The FSM SHALL leave PRE as follows:
- Symbol 0xD5, or nibble 0xD, with preamble count >= MINPRE -> DATA.
- 0x55 or nibble 0x5 -> stay in PRE and increment the count.
- Anything else, or an SFD that comes too early -> DROP.
- dv=0 -> IDLE with no output.
REQ-009 In DROP the FSM SHALL emit nothing and SHALL return to IDLE on the first cycle with dv=0.
REQ-010 In nibble mode, byte phase SHALL be set by the SFD nibble; the nibble that follows the SFD is the low nibble of byte 0.
REQ-011 In DATA, each assembled byte SHALL go through a one-byte hold register. The held byte SHALL be output with ovld=1 when the next byte completes, or when dv=0 is sampled, in which case oeof=1.
REQ-012 Latency from idat sampling to odat SHALL be 2 rxclk in 1G mode and 3 rxclk in nibble mode.
REQ-013 osof SHALL be 1 only with the first byte of the frame. A one-byte frame SHALL assert osof and oeof together.
REQ-014 oerr SHALL be 1 with oeof if any of the following occurred in DATA:
- er=1 on any cycle;
- odd nibble count at dv fall (the partial nibble is discarded);
- olen > MAXLEN.
REQ-015 An error SHALL NOT suppress any byte output.
REQ-016 olen SHALL count bytes output in the frame, including the last byte, and SHALL saturate at 16383.
REQ-017 dv falling in DATA before any complete byte SHALL return the FSM to IDLE with no output.
REQ-018 ovld, osof and oeof SHALL be single-cycle pulses. odat SHALL hold its last value when ovld=0.
REQ-019 In IDLE, dv=0 with er=1 (false carrier or extension) SHALL be ignored.
REQ-020 A new frame SHALL be accepted on the cycle immediately after the dv=0 cycle that produced oeof.

Reset
REQ-021 When rxrst_=0, the block SHALL force the FSM to IDLE, clear all counters and the hold register, and drive all outputs to 0, asynchronously.
REQ-022 A reset asserted mid-frame SHALL abandon the frame with no oeof.
REQ-023 After reset release, the block SHALL NOT emit bytes until a full preamble and SFD have been seen.
REQ-024 After reset, olink, ospeed and oduplex SHALL read 0 until the first in-band update.

Configuration
REQ-025 With IPSMACGE_RGMIIRX_INBAND_EN defined, the block SHALL update {oduplex, ospeed, olink} from idat_h[3:0] (bit3 duplex, bits 2:1 speed, bit0 link) when all of these hold:
- dv=0;
- er=0;
- idat_h[3:0]==idat_l[3:0];
- the same value has been seen for 2 consecutive cycles.
REQ-026 The in-band status outputs SHALL otherwise hold their value.
REQ-027 Without IPSMACGE_RGMIIRX_INBAND_EN, the block SHALL tie olink=1, ospeed=2'b10 and oduplex=1, and SHALL contain no in-band logic.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- 1G, 7x0x55 + 0xD5 + 64 bytes 0x00..0x3F -> 64 ovld pulses, osof on 0x00, oeof on 0x3F, olen=64, oerr=0, first odat 2 clocks after its idat.
- Nibble mode, same frame as nibbles -> identical byte stream, ovld every other cycle, olen=64; a trailing extra nibble -> oerr=1, olen=64.
- 1G, er=1 on byte 10 of a 100-byte frame -> all 100 bytes output, oerr=1 at oeof, olen=100.
- 1G, 1600-byte frame with MAXLEN=1522 -> olen=1600, oerr=1; preamble 0x55,0x57 -> DROP, no ovld until next valid frame.
- Reset pulse at byte 20 -> outputs 0 at once, no oeof; next frame received normally. Back-to-back frames with one dv=0 cycle -> both received.
- INBAND_EN defined, idle nibble 0xD on both edges for 2 cycles -> olink=1, ospeed=2'b10, oduplex=1; a single-cycle glitch -> no change.
